// File: rtl/recv_control.sv
// Receive-side round sequencer: accepts the first good copy of each segment per aux round,
// drops redundant/bad headers and reports missing segments when a round closes.
module recv_control #(
  parameter int unsigned MAX_SEGS = 64,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic        clk125MHz,
  input  logic        rst_n,
  input  logic [15:0] segment_num_max,
  input  logic [7:0]  redundancy,
  input  logic        hdr_valid,
  input  logic        crc_ok,
  input  logic [15:0] rx_segment_num,
  input  logic [7:0]  rx_txid,
  input  logic [7:0]  rx_aux,
  output logic        accept,
  output logic [15:0] accept_segment_num,
  output logic [7:0]  accept_txid,
  output logic        frame_done,
  output logic [7:0]  frame_aux,
  output logic [15:0] missing_count,
  output logic [15:0] dup_count,
  output logic [15:0] bad_count
);
  localparam int unsigned IDXW     = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;
  localparam logic [16:0] SEGS_LIM = 17'(MAX_SEGS);
  localparam logic [27:0] TO_LAST  = 28'(TIMEOUT - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state, state_d;
  logic [7:0]          cur_aux, cur_aux_d;
  logic [7:0]          last_aux, last_aux_d;
  logic                closed_vld, closed_vld_d;
  logic [MAX_SEGS-1:0] bitmap, bitmap_d;
  logic [15:0]         recv_cnt, recv_cnt_d, recv_inc;
  logic [27:0]         tcnt, tcnt_d;
  logic                accept_d, frame_done_d;
  logic [15:0]         accept_segment_num_d, missing_count_d, dup_count_d, bad_count_d;
  logic [7:0]          accept_txid_d, frame_aux_d;
  logic                hdr_bad, open_round;
  logic [IDXW-1:0]     idx;

  assign idx      = rx_segment_num[IDXW-1:0];
  assign recv_inc = recv_cnt + 16'd1;
  assign hdr_bad  = !crc_ok
                 || (rx_segment_num >= segment_num_max)
                 || ({1'b0, rx_segment_num} >= SEGS_LIM)
                 || (rx_txid == 8'd0)
                 || (rx_txid > redundancy);

  always_comb begin
    state_d              = state;
    cur_aux_d            = cur_aux;
    last_aux_d           = last_aux;
    closed_vld_d         = closed_vld;
    bitmap_d             = bitmap;
    recv_cnt_d           = recv_cnt;
    tcnt_d               = tcnt;
    accept_d             = 1'b0;
    accept_segment_num_d = accept_segment_num;
    accept_txid_d        = accept_txid;
    frame_done_d         = 1'b0;
    frame_aux_d          = frame_aux;
    missing_count_d      = missing_count;
    dup_count_d          = dup_count;
    bad_count_d          = bad_count;
    open_round           = 1'b0;

    if (hdr_valid) begin
      tcnt_d = '0;
    end else if (state == COLLECT) begin
      tcnt_d = tcnt + 28'd1;
    end

    if (hdr_valid && hdr_bad) begin
      if (bad_count != '1) bad_count_d = bad_count + 16'd1;
    end else if (hdr_valid) begin
      if (state == IDLE) begin
        if (closed_vld && (rx_aux == last_aux)) begin
          if (dup_count != '1) dup_count_d = dup_count + 16'd1;
        end else begin
          open_round = 1'b1;
        end
      end else if (rx_aux == cur_aux) begin
        if (bitmap[idx]) begin
          if (dup_count != '1) dup_count_d = dup_count + 16'd1;
        end else begin
          bitmap_d[idx]        = 1'b1;
          recv_cnt_d           = recv_inc;
          accept_d             = 1'b1;
          accept_segment_num_d = rx_segment_num;
          accept_txid_d        = rx_txid;
          if (recv_inc == segment_num_max) begin
            frame_done_d    = 1'b1;
            frame_aux_d     = cur_aux;
            missing_count_d = '0;
            last_aux_d      = cur_aux;
            closed_vld_d    = 1'b1;
            state_d         = IDLE;
          end
        end
      end else begin
        frame_done_d    = 1'b1;
        frame_aux_d     = cur_aux;
        missing_count_d = segment_num_max - recv_cnt;
        open_round      = 1'b1;
      end
    end else if ((state == COLLECT) && (tcnt == TO_LAST)) begin
      frame_done_d    = 1'b1;
      frame_aux_d     = cur_aux;
      missing_count_d = segment_num_max - recv_cnt;
      last_aux_d      = cur_aux;
      closed_vld_d    = 1'b1;
      tcnt_d          = '0;
      state_d         = IDLE;
    end

    // A single-segment round completes in the same cycle it opens.
    if (open_round) begin
      cur_aux_d            = rx_aux;
      bitmap_d             = '0;
      bitmap_d[idx]        = 1'b1;
      recv_cnt_d           = 16'd1;
      accept_d             = 1'b1;
      accept_segment_num_d = rx_segment_num;
      accept_txid_d        = rx_txid;
      if (segment_num_max == 16'd1) begin
        frame_done_d    = 1'b1;
        frame_aux_d     = rx_aux;
        missing_count_d = '0;
        last_aux_d      = rx_aux;
        closed_vld_d    = 1'b1;
        state_d         = IDLE;
      end else begin
        state_d = COLLECT;
      end
    end
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cur_aux            <= '0;
      last_aux           <= '0;
      closed_vld         <= 1'b0;
      bitmap             <= '0;
      recv_cnt           <= '0;
      tcnt               <= '0;
      accept             <= 1'b0;
      accept_segment_num <= '0;
      accept_txid        <= '0;
      frame_done         <= 1'b0;
      frame_aux          <= '0;
      missing_count      <= '0;
      dup_count          <= '0;
      bad_count          <= '0;
    end else begin
      state              <= state_d;
      cur_aux            <= cur_aux_d;
      last_aux           <= last_aux_d;
      closed_vld         <= closed_vld_d;
      bitmap             <= bitmap_d;
      recv_cnt           <= recv_cnt_d;
      tcnt               <= tcnt_d;
      accept             <= accept_d;
      accept_segment_num <= accept_segment_num_d;
      accept_txid        <= accept_txid_d;
      frame_done         <= frame_done_d;
      frame_aux          <= frame_aux_d;
      missing_count      <= missing_count_d;
      dup_count          <= dup_count_d;
      bad_count          <= bad_count_d;
    end
  end
endmodule

// File: tb/tb_recv_control.sv
// Scoreboard bench for recv_control: a per-header reference model queues expected
// accept/frame_done events; an independent monitor checks them as the DUT emits them.
module tb_recv_control;
  localparam int MAX_SEGS_TB = 64;
  localparam int TO_TB       = 100;

  logic        clk125MHz = 1'b0;
  logic        rst_n;
  logic [15:0] segment_num_max;
  logic [7:0]  redundancy;
  logic        hdr_valid, crc_ok;
  logic [15:0] rx_segment_num;
  logic [7:0]  rx_txid, rx_aux;
  logic        accept, frame_done;
  logic [15:0] accept_segment_num, missing_count, dup_count, bad_count;
  logic [7:0]  accept_txid, frame_aux;

  recv_control #(.MAX_SEGS(MAX_SEGS_TB), .TIMEOUT(TO_TB)) dut (
    .clk125MHz(clk125MHz), .rst_n(rst_n),
    .segment_num_max(segment_num_max), .redundancy(redundancy),
    .hdr_valid(hdr_valid), .crc_ok(crc_ok),
    .rx_segment_num(rx_segment_num), .rx_txid(rx_txid), .rx_aux(rx_aux),
    .accept(accept), .accept_segment_num(accept_segment_num), .accept_txid(accept_txid),
    .frame_done(frame_done), .frame_aux(frame_aux), .missing_count(missing_count),
    .dup_count(dup_count), .bad_count(bad_count)
  );

  always #4 clk125MHz = ~clk125MHz;

  int cyc = 0;
  always @(posedge clk125MHz) cyc <= cyc + 1;

  typedef struct {
    int cyc; bit acc; int aseg; int atx; bit fd; int faux; int miss;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_mis = 0, n_acc = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: round membership as a set of seen segments per aux value.
  int smax, red;
  bit m_open, m_closed;
  int m_cur, m_last, m_idle, m_dup, m_bad;
  bit m_seen[MAX_SEGS_TB];
  exp_t m_e;

  function automatic int seen_cnt();
    int n = 0;
    foreach (m_seen[i]) n += int'(m_seen[i]);
    return n;
  endfunction

  function automatic void model_reset();
    m_open = 0; m_closed = 0; m_cur = 0; m_last = 0;
    m_idle = 0; m_dup = 0; m_bad = 0;
    foreach (m_seen[i]) m_seen[i] = 0;
  endfunction

  function automatic void close_round(int aux, int miss);
    m_e.fd = 1; m_e.faux = aux; m_e.miss = miss;
    m_open = 0; m_last = aux; m_closed = 1;
  endfunction

  function automatic void take(int seg, int tx);
    m_seen[seg] = 1; m_e.acc = 1; m_e.aseg = seg; m_e.atx = tx;
  endfunction

  function automatic void model_step(bit hv, bit crc, int seg, int tx, int aux);
    bit opn = 0;
    m_e = '{cyc: cyc + 1, default: 0};
    if (hv) begin
      m_idle = 0;
      if (!crc || seg >= smax || seg >= MAX_SEGS_TB || tx == 0 || tx > red) begin
        if (m_bad < 65535) m_bad++;
      end else if (!m_open) begin
        if (m_closed && aux == m_last) begin
          if (m_dup < 65535) m_dup++;
        end else opn = 1;
      end else if (aux == m_cur) begin
        if (m_seen[seg]) begin
          if (m_dup < 65535) m_dup++;
        end else begin
          take(seg, tx);
          if (seen_cnt() == smax) close_round(m_cur, 0);
        end
      end else begin
        close_round(m_cur, smax - seen_cnt());
        opn = 1;
      end
      if (opn) begin
        foreach (m_seen[i]) m_seen[i] = 0;
        take(seg, tx);
        m_cur = aux; m_open = 1;
        if (smax == 1) close_round(aux, 0);
      end
    end else if (m_open) begin
      m_idle++;
      if (m_idle == TO_TB) begin
        close_round(m_cur, smax - seen_cnt());
        m_idle = 0;
      end
    end
    if (m_e.acc || m_e.fd) q.push_back(m_e);
  endfunction

  task automatic tick(bit hv, bit crc, int seg, int tx, int aux);
    @(negedge clk125MHz);
    hdr_valid = hv; crc_ok = crc;
    rx_segment_num = 16'(seg); rx_txid = 8'(tx); rx_aux = 8'(aux);
    model_step(hv, crc, seg, tx, aux);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(int sm, int rd);
    @(negedge clk125MHz);
    rst_n = 1'b0; hdr_valid = 1'b0;
    segment_num_max = 16'(sm); redundancy = 8'(rd);
    smax = sm; red = rd;
    model_reset(); q.delete();
    repeat (2) @(negedge clk125MHz);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_accept"}, accept, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_accept_seg"}, accept_segment_num, 0);
    chk({tag, "_accept_txid"}, accept_txid, 0);
    chk({tag, "_frame_aux"}, frame_aux, 0);
    chk({tag, "_missing"}, missing_count, 0);
    chk({tag, "_dup"}, dup_count, 0);
    chk({tag, "_bad"}, bad_count, 0);
  endtask

  // Monitor: every DUT output pulse must match the oldest expected event and its cycle.
  exp_t mon_e;
  always @(negedge clk125MHz) begin
    if (rst_n) begin
      if (accept) n_acc++;
      if (accept || frame_done) begin
        if (q.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_output: got accept=%0b frame_done=%0b expected none (cycle %0d)",
                   accept, frame_done, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("accept", accept, mon_e.acc);
          if (mon_e.acc) begin
            chk("accept_segment_num", accept_segment_num, mon_e.aseg);
            chk("accept_txid", accept_txid, mon_e.atx);
          end
          chk("frame_done", frame_done, mon_e.fd);
          if (mon_e.fd) begin
            chk("frame_aux", frame_aux, mon_e.faux);
            chk("missing_count", missing_count, mon_e.miss);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        n_cmp++; n_mis++;
        $display("FAIL missing_output: got none expected accept=%0b frame_done=%0b (cycle %0d)",
                 mon_e.acc, mon_e.fd, mon_e.cyc);
      end
    end
  end

  int a0;

  initial begin
    rst_n = 1'b0; hdr_valid = 1'b0; crc_ok = 1'b0;
    rx_segment_num = '0; rx_txid = '0; rx_aux = '0;
    segment_num_max = 16'd4; redundancy = 8'd3; smax = 4; red = 3;
    model_reset();
    repeat (2) @(negedge clk125MHz);
    #1 check_zero("reset");
    rst_n = 1'b1;

    // Basic round: full transmit order, three copies of four segments.
    a0 = n_acc;
    for (int t = 1; t <= 3; t++)
      for (int s = 0; s < 4; s++) tick(1, 1, s, t, 0);
    idle(2);
    chk("basic_accepts", n_acc - a0, 4);
    chk("basic_dup", dup_count, 8);
    chk("basic_bad", bad_count, 0);
    chk("basic_frame_aux", frame_aux, 0);
    chk("basic_missing", missing_count, 0);

    // Loss of segment 2, then a new aux closes the round; recovery after a CRC error.
    do_reset(4, 3);
    for (int t = 1; t <= 3; t++)
      for (int s = 0; s < 4; s++) if (s != 2) tick(1, 1, s, t, 0);
    tick(1, 1, 0, 1, 1);
    idle(2);
    chk("loss_frame_aux", frame_aux, 0);
    chk("loss_missing", missing_count, 1);
    chk("loss_accept_seg", accept_segment_num, 0);
    tick(1, 0, 1, 1, 1);
    tick(1, 1, 1, 2, 1);
    idle(2);
    chk("recovery_bad", bad_count, 1);
    chk("recovery_txid", accept_txid, 2);

    // Range and txid checks.
    do_reset(4, 3);
    a0 = n_acc;
    tick(1, 1, 4, 1, 1);
    tick(1, 1, 0, 0, 1);
    tick(1, 1, 0, 4, 1);
    idle(2);
    chk("range_bad", bad_count, 3);
    chk("range_accepts", n_acc - a0, 0);

    // Timeout with aux=255, late copies, then aux=0 wraps into a new round.
    do_reset(4, 3);
    tick(1, 1, 0, 1, 255);
    tick(1, 1, 1, 1, 255);
    idle(TO_TB + 2);
    chk("timeout_frame_aux", frame_aux, 255);
    chk("timeout_missing", missing_count, 2);
    tick(1, 1, 2, 1, 255);
    tick(1, 1, 3, 2, 255);
    idle(2);
    chk("late_dup", dup_count, 2);
    a0 = n_acc;
    tick(1, 1, 0, 1, 0);
    idle(1);

    // Asynchronous reset mid-round.
    #2 rst_n = 1'b0;
    model_reset(); q.delete();
    #1 check_zero("midreset");
    chk("wrap_accepts", n_acc - a0, 1);
    repeat (2) @(negedge clk125MHz);
    rst_n = 1'b1;
    a0 = n_acc;
    tick(1, 1, 0, 1, 255);
    idle(2);
    chk("post_reset_accepts", n_acc - a0, 1);
    chk("post_reset_dup", dup_count, 0);

    // Single-segment rounds complete on open.
    do_reset(1, 2);
    tick(1, 1, 0, 1, 5);
    tick(1, 1, 0, 2, 5);
    tick(1, 1, 0, 1, 6);
    idle(2);
    chk("single_dup", dup_count, 1);
    chk("single_frame_aux", frame_aux, 6);

    // Randomized traffic.
    do_reset(6, 2);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) idle(TO_TB + $urandom_range(0, 5));
      else if ($urandom_range(0, 99) < 60)
        tick(1, $urandom_range(0, 9) != 0, int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else tick(0, 0, 0, 0, 0);
    end
    idle(3);
    chk("random_dup", dup_count, m_dup);
    chk("random_bad", bad_count, m_bad);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/recv_control.md
# recv_control

Receive-side sequencing controller, the counterpart of `send_control`. It consumes one header strobe per CRC-checked received frame, carrying `segment_num`, `txid` and `aux`. For each round (one `aux` value), it accepts the first good copy of every segment and rejects redundant copies. It closes the round on completion, on a new `aux` or on timeout, then reports the number of missing segments. `accept` drives the write enable of the receive segment RAM, and `frame_done` notifies the display/readout logic.

## Interface
- `MAX_SEGS`, 64: bitmap size; the highest supported `segment_num_max`.
- `TIMEOUT`, 1_000_000: idle cycles in COLLECT before a forced close. 28-bit counter.
- `clk125MHz` in 1: sole clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `segment_num_max` in 16: segments per round. Same source as the transmitter setting. Static during operation.
- `redundancy` in 8: copies sent per segment. Static during operation.
- `hdr_valid` in 1: one-cycle strobe, header fields valid.
- `crc_ok` in 1: qualifies `hdr_valid`.
- `rx_segment_num` in 16; `rx_txid` in 8; `rx_aux` in 8: received header fields.
- `accept` out 1: one-cycle pulse; write this segment to RAM.
- `accept_segment_num` out 16; `accept_txid` out 8: fields of the accepted frame; hold until the next accept.
- `frame_done` out 1: one-cycle pulse; round closed.
- `frame_aux` out 8; `missing_count` out 16: describe the closed round; hold until the next `frame_done`.
- `dup_count`, `bad_count` out 16 each: saturating counters, stick at 0xFFFF.

## Operation
- States:
  - IDLE: no open round.
  - COLLECT: round open; `cur_aux`, `bitmap[MAX_SEGS-1:0]` and `recv_cnt` are valid.
- Each `hdr_valid` strobe is classified once, with the priority below.
  1. `crc_ok=0`: `bad_count++`. No other effect.
  2. Any of the following → `bad_count++` and drop:
     - `rx_segment_num >= segment_num_max`
     - `rx_segment_num >= MAX_SEGS`
     - `rx_txid == 0`
     - `rx_txid > redundancy`
  3. IDLE, with `closed_vld=1` and `rx_aux == last_aux`: late copy of the closed round. `dup_count++`, drop.
  4. IDLE, any other `rx_aux`: open a round. Set `cur_aux <= rx_aux`, set the bitmap to this segment's bit only, set `recv_cnt <= 1`, accept, go to COLLECT.
  5. COLLECT, `rx_aux == cur_aux`, bit already set: `dup_count++`, drop.
  6. COLLECT, `rx_aux == cur_aux`, bit clear: set the bit, `recv_cnt++`, accept.
     - If the new `recv_cnt == segment_num_max`, close the round in the same cycle with `missing_count = 0`.
     - Then go to IDLE with `last_aux <= cur_aux` and `closed_vld <= 1`.
  7. COLLECT, `rx_aux != cur_aux`: close the old round and open the new one in the same cycle.
     - Close: `frame_aux = cur_aux`, `missing_count = segment_num_max - recv_cnt`.
     - Open: apply rule 4 to the new header.
     - Stay in COLLECT.
- Timeout: the counter clears on every `hdr_valid` and counts in COLLECT. At `TIMEOUT`:
  - close the round with `missing_count = segment_num_max - recv_cnt`;
  - set `last_aux <= cur_aux`, `closed_vld <= 1`;
  - go to IDLE.
- `aux` comparisons are equality only, so the 255→0 wrap needs no special case.
- Round opened with `segment_num_max == 1`: it completes immediately. `frame_done` and `accept` fire together.

## Timing
- Registered outputs, one-cycle latency: `hdr_valid` in cycle N → `accept` and/or `frame_done` in cycle N+1. Counters update at N+1.
- No backpressure. Back-to-back `hdr_valid` strobes on consecutive cycles are each classified.
- Reset values:
  - `accept`, `frame_done`: 0.
  - All field outputs and counters: 0.
  - State IDLE; `closed_vld = 0`; bitmap clear; timeout counter 0.
- `rst_n` asserted mid-round: everything returns to the reset values immediately. No `frame_done` is issued for the abandoned round.
- Timeout close and `hdr_valid` in the same cycle: the header wins and the timeout is ignored that cycle.

## Test plan
- Basic round: `segment_num_max=4`, `redundancy=3`, `aux=0`. Send the full transmit order: `txid` 1, 2, 3, each covering segments 0–3.
  - Expect exactly 4 `accept` pulses (txid=1, segments 0–3).
  - Expect `frame_done` one cycle after segment 3 with `frame_aux=0` and `missing_count=0`.
  - Expect `dup_count=8`.
- Loss: same settings. Segment 2 is never sent with any `txid`; then a header with `aux=1`, segment 0.
  - Expect `frame_done` with `frame_aux=0` and `missing_count=1`.
  - In the same cycle, expect `accept` with `accept_segment_num=0`, and the round for `aux=1` is open.
- Recovery: send `txid=1`, segment 1 with `crc_ok=0`, then `txid=2`, segment 1 with `crc_ok=1`.
  - Expect `bad_count=1`, then `accept` with `accept_txid=2`.
- Range and txid checks: headers with `segment_num=4` (max=4), `txid=0` and `txid=4` (redundancy=3).
  - Expect `bad_count=3` and no `accept`.
- Timeout and wrap: `TIMEOUT=100`. Open `aux=255`, send 2 of 4 segments, then idle for 100 cycles.
  - Expect `frame_done` with `missing_count=2`.
  - Late `aux=255` copies afterwards increment `dup_count`.
  - `aux=0` then opens a new round.
- Reset: assert `rst_n=0` mid-round.
  - Expect all outputs at 0 asynchronously and no `frame_done`.
  - After release, the next `aux=255` header opens a fresh round, because `closed_vld=0`.
